// File: rtl/net_stream_tx.sv
// Frame-gated stream transmitter: buffers host words in a show-ahead FIFO and releases whole frames.
// Optional `STREAM_TX_LAST_EN adds output_last marking the final word of each frame.
module net_stream_tx #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 16,
    parameter int FRAME_LEN = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     output_valid,
    input  logic                     output_ready,
    output logic [WIDTH-1:0]         output_data,
    output logic                     frame_done,
    output logic [15:0]              frames_sent,
    output logic [$clog2(DEPTH):0]   level
`ifdef STREAM_TX_LAST_EN
    ,
    output logic                     output_last
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               frame_done_q, frame_done_d;
    logic [15:0]        frames_sent_q, frames_sent_d;
    logic [WIDTH-1:0]   mem [DEPTH];

    logic push, pop, last_word;

    // Space is judged on registered occupancy only, so a same-cycle pop never frees a slot.
    assign wr_ready     = (level_q < LVL_W'(DEPTH));
    assign output_valid = (state_q == SEND);
    assign output_data  = mem[rd_ptr_q];
    assign push         = wr_valid & wr_ready;
    assign pop          = output_valid & output_ready;
    assign last_word    = (word_cnt_q == CNT_W'(FRAME_LEN - 1));

    assign level        = level_q;
    assign frame_done   = frame_done_q;
    assign frames_sent  = frames_sent_q;

`ifdef STREAM_TX_LAST_EN
    assign output_last  = output_valid & last_word;
`endif

    always_comb begin
        level_d       = level_q + LVL_W'(push) - LVL_W'(pop);
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        frame_done_d  = 1'b0;
        frames_sent_d = frames_sent_q;
        case (state_q)
            IDLE: begin
                if (level_q >= LVL_W'(FRAME_LEN)) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (pop) begin
                    if (last_word) begin
                        word_cnt_d    = '0;
                        frame_done_d  = 1'b1;
                        frames_sent_d = frames_sent_q + 16'd1;
                        // Stay in SEND when the next frame is already fully buffered.
                        if (level_d < LVL_W'(FRAME_LEN)) begin
                            state_d = IDLE;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            word_cnt_q    <= '0;
            frame_done_q  <= 1'b0;
            frames_sent_q <= '0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            word_cnt_q    <= word_cnt_d;
            frame_done_q  <= frame_done_d;
            frames_sent_q <= frames_sent_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage is data only and carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_net_stream_tx.sv
// Directed bench for net_stream_tx: frame gating, back-to-back frames, full-FIFO stall, async reset.
// With STREAM_TX_LAST_EN defined it also checks output_last under random back-pressure.
module tb_net_stream_tx;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_data;
    logic        output_valid;
    logic        output_ready;
    logic [15:0] output_data;
    logic        frame_done;
    logic [15:0] frames_sent;
    logic [4:0]  level;
`ifdef STREAM_TX_LAST_EN
    logic        output_last;
`endif

    net_stream_tx #(.WIDTH(16), .DEPTH(16), .FRAME_LEN(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .output_valid (output_valid),
        .output_ready (output_ready),
        .output_data  (output_data),
        .frame_done   (frame_done),
        .frames_sent  (frames_sent),
        .level        (level)
`ifdef STREAM_TX_LAST_EN
        ,
        .output_last  (output_last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          pushed = 0;
    int          fd_cnt = 0;
    int          rises  = 0;
    logic [15:0] rx[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Record the transfer about to happen at the next edge, then advance to 1 time unit after it.
    task automatic tick();
        logic prev_v;
        prev_v = output_valid;
        if (output_valid && output_ready) rx.push_back(output_data);
        if (wr_valid && wr_ready) pushed++;
        @(posedge clk);
        #1;
        if (frame_done) fd_cnt++;
        if (output_valid && !prev_v) rises++;
    endtask

    task automatic push_seq(input int n, input logic [15:0] base);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + 16'(i);
            tick();
        end
        wr_valid = 1'b0;
    endtask

    task automatic check_rx(input string tag, input int n, input logic [15:0] base);
        chk({tag, "_count"}, 32'(rx.size()), 32'(n));
        for (int k = 0; k < n && k < rx.size(); k++) begin
            chk({tag, "_word"}, {16'h0, rx[k]}, {16'h0, base + 16'(k)});
        end
    endtask

    initial begin
        reset        = 1'b1;
        wr_valid     = 1'b0;
        wr_data      = '0;
        output_ready = 1'b1;
        #12;
        chk("rst_wr_ready", {31'h0, wr_ready}, 32'd1);
        chk("rst_valid",    {31'h0, output_valid}, 32'd0);
        chk("rst_level",    {27'h0, level}, 32'd0);
        chk("rst_frames",   {16'h0, frames_sent}, 32'd0);
        chk("rst_done",     {31'h0, frame_done}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: single frame, output_valid one cycle after level reaches 4
        push_seq(4, 16'h0001);
        chk("t1_level4",   {27'h0, level}, 32'd4);
        chk("t1_not_yet",  {31'h0, output_valid}, 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t1_valid", {31'h0, output_valid}, 32'd1);
            chk("t1_data",  {16'h0, output_data}, 32'(k + 1));
            tick();
        end
        chk("t1_done",     {31'h0, frame_done}, 32'd1);
        chk("t1_idle",     {31'h0, output_valid}, 32'd0);
        chk("t1_frames",   {16'h0, frames_sent}, 32'd1);
        chk("t1_level0",   {27'h0, level}, 32'd0);
        tick();
        chk("t1_done_off", {31'h0, frame_done}, 32'd0);

        // 2: partial frame waits until completed
        rx.delete();
        push_seq(3, 16'h0011);
        repeat (10) tick();
        chk("t2_hold_valid", {31'h0, output_valid}, 32'd0);
        chk("t2_hold_level", {27'h0, level}, 32'd3);
        push_seq(1, 16'h0014);
        tick();
        chk("t2_valid", {31'h0, output_valid}, 32'd1);
        repeat (6) tick();
        check_rx("t2_rx", 4, 16'h0011);
        chk("t2_frames", {16'h0, frames_sent}, 32'd2);

        // 3: two frames back-to-back without a valid gap
        rx.delete();
        fd_cnt = 0;
        rises  = 0;
        push_seq(8, 16'h0021);
        repeat (10) tick();
        check_rx("t3_rx", 8, 16'h0021);
        chk("t3_rises",  32'(rises), 32'd1);
        chk("t3_done",   32'(fd_cnt), 32'd2);
        chk("t3_frames", {16'h0, frames_sent}, 32'd4);

        // 4: fill to full under stall, then drain 20 words
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        rx.delete();
        pushed       = 0;
        fd_cnt       = 0;
        output_ready = 1'b0;
        repeat (24) begin
            wr_valid = (pushed < 20);
            wr_data  = 16'(32'h0101 + 32'(pushed));
            tick();
            if (output_valid) chk("t4_stall_data", {16'h0, output_data}, 32'h0101);
        end
        chk("t4_pushed",   32'(pushed), 32'd16);
        chk("t4_full",     {27'h0, level}, 32'd16);
        chk("t4_wr_ready", {31'h0, wr_ready}, 32'd0);
        chk("t4_valid",    {31'h0, output_valid}, 32'd1);
        output_ready = 1'b1;
        repeat (40) begin
            wr_valid = (pushed < 20);
            wr_data  = 16'(32'h0101 + 32'(pushed));
            tick();
        end
        wr_valid = 1'b0;
        check_rx("t4_rx", 20, 16'h0101);
        chk("t4_frames", {16'h0, frames_sent}, 32'd5);
        chk("t4_done",   32'(fd_cnt), 32'd5);
        chk("t4_level0", {27'h0, level}, 32'd0);

        // 5: asynchronous reset mid-frame, then a clean frame
        rx.delete();
        push_seq(4, 16'h0201);
        tick();
        tick();
        tick();
        chk("t5_sent2", 32'(rx.size()), 32'd2);
        reset = 1'b1;
        #1;
        chk("t5_rst_valid",  {31'h0, output_valid}, 32'd0);
        chk("t5_rst_level",  {27'h0, level}, 32'd0);
        chk("t5_rst_frames", {16'h0, frames_sent}, 32'd0);
        #1;
        reset = 1'b0;
        tick();
        chk("t5_after_valid", {31'h0, output_valid}, 32'd0);
        rx.delete();
        push_seq(4, 16'h0301);
        repeat (8) tick();
        check_rx("t5_rx", 4, 16'h0301);
        chk("t5_frames", {16'h0, frames_sent}, 32'd1);

`ifdef STREAM_TX_LAST_EN
        // 6: output_last tracks the 4th word and holds through stalls
        begin
            logic        pv_stall;
            logic [15:0] pv_data;
            logic        pv_last;
            pv_stall = 1'b0;
            pv_data  = '0;
            pv_last  = 1'b0;
            rx.delete();
            pushed = 0;
            repeat (80) begin
                wr_valid     = (pushed < 8);
                wr_data      = 16'(32'h0401 + 32'(pushed));
                output_ready = 1'($urandom_range(0, 1));
                if (output_valid) begin
                    chk("t6_last", {31'h0, output_last}, {31'h0, (rx.size() % 4) == 3});
                    if (pv_stall) begin
                        chk("t6_hold_data", {16'h0, output_data}, {16'h0, pv_data});
                        chk("t6_hold_last", {31'h0, output_last}, {31'h0, pv_last});
                    end
                end else begin
                    chk("t6_last_idle", {31'h0, output_last}, 32'd0);
                end
                pv_stall = output_valid && !output_ready;
                pv_data  = output_data;
                pv_last  = output_last;
                tick();
            end
            wr_valid     = 1'b0;
            output_ready = 1'b1;
            repeat (12) tick();
            check_rx("t6_rx", 8, 16'h0401);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
